frame_queue_ctrl: RTL and testbench
===================================

FRAME_QUEUE_CTRL -- requirements
Module: frame_queue_ctrl

Interface
REQ-001 Parameter HDR, 8'hAB, frame header byte value.
REQ-002 Parameter DEPTH, 16, payload FIFO depth in bytes; fixed at 16 (4-bit pointers).
REQ-003 ser_clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 byte_in  input  8  parallel byte from the upstream framer stage.
REQ-006 byte_stb  input  1  one-cycle strobe; byte_in valid when high (at most once per 8 ser_clk cycles in system use; the block SHALL accept back-to-back strobes).
REQ-007 rd_en  input  1  consumer pop request.
REQ-008 rd_data  output  8  FIFO head byte, show-ahead; valid only while empty=0.
REQ-009 empty  output  1  FIFO holds 0 bytes.
REQ-010 full  output  1  FIFO holds DEPTH bytes.
REQ-011 count  output  5  FIFO occupancy, 0..16.
REQ-012 state  output  2  FSM state: 0=HUNT, 1=LEN, 2=PAYLOAD.
REQ-013 frame_done  output  1  one-cycle pulse at the end of a valid frame.
REQ-014 len_err  output  1  one-cycle pulse on an illegal length byte.
REQ-015 overflow  output  1  sticky; payload byte dropped because FIFO was full.

Function
REQ-016 The FSM SHALL act only in cycles where byte_stb=1; with byte_stb=0 state and remaining are held.
REQ-017 HUNT: byte_in==HDR -> LEN; any other byte is discarded, stay HUNT.
REQ-018 LEN: length L=byte_in; L==0 -> frame_done pulse, -> HUNT; L>DEPTH -> len_err pulse, -> HUNT; else remaining<=L, -> PAYLOAD.
REQ-019 LEN SHALL treat a byte equal to HDR as a length value (171 -> len_err), not as a new header.
REQ-020 PAYLOAD: each strobe writes byte_in to FIFO if not full (or full with same-cycle pop), else drops it and sets overflow; remaining decrements in both cases.
REQ-021 PAYLOAD with remaining==1 at strobe: write/drop the byte, pulse frame_done the following cycle, -> HUNT.
REQ-022 frame_done and len_err SHALL be registered, asserted exactly one cycle after the deciding strobe edge.
REQ-023 Payload bytes equal to HDR SHALL be stored as data.
REQ-024 FIFO: write pointer, read pointer 4-bit, wrap 15->0; count 5-bit; full=(count==16), empty=(count==0).
REQ-025 rd_en with empty=1 SHALL be ignored (no pointer or count change).
REQ-026 Simultaneous write and pop: both performed, count unchanged; permitted when full (no drop) and when empty the write occurs and the pop is ignored (count +1).
REQ-027 rd_data SHALL equal mem[rd_ptr] combinationally; after a pop it shows the next byte in the cycle following the pop edge.
REQ-028 FIFO contents SHALL be in exact arrival order across frames; frame boundaries are not stored.
REQ-029 Unknown state encoding (3) SHALL return to HUNT on the next clock.

Reset
REQ-030 reset_n=0 SHALL immediately force state=HUNT, remaining=0, pointers=0, count=0, empty=1, full=0, frame_done=0, len_err=0, overflow=0.
REQ-031 Reset mid-frame SHALL discard the partial frame and all buffered bytes; memory contents need not be cleared.
REQ-032 overflow SHALL clear only by reset.
REQ-033 First active edge after reset_n rises SHALL be processed normally.

Verification
REQ-034 Strobes AB,03,11,22,33 -> state 0,1,2,2,2,0; frame_done one pulse after 0x33; count=3; pops return 11,22,33 then empty=1.
REQ-035 Strobes AB,00 -> frame_done pulse, count=0, state HUNT; strobes AB,11 -> len_err pulse, state HUNT, count=0.
REQ-036 Strobes 55,AB,AB -> 55 discarded, second AB gives len_err; then AB,02,AB,AB -> two bytes 0xAB stored, frame_done.
REQ-037 Frame length 16 then frame length 2 with no pops -> count=16, full=1, both bytes of frame 2 dropped, overflow=1, frame_done pulses for both frames.
REQ-038 count=16 with pop and write same cycle -> count stays 16, no overflow; 20 pops over 20 cycles -> 16 bytes out in order, pointer wrap verified, last 4 pops ignored.
REQ-039 reset_n pulsed low asynchronously mid-PAYLOAD with count=5 -> outputs at reset values before next ser_clk edge; subsequent AB,01,7E -> count=1, rd_data=7E.

Source files
------------

// File: rtl/frame_queue_ctrl.sv
// rtl/frame_queue_ctrl.sv - header/length frame parser feeding a 16-byte show-ahead payload FIFO
module frame_queue_ctrl #(
   parameter logic [7:0] HDR   = 8'hAB,
   parameter int         DEPTH = 16
) (
   input  logic       ser_clk,
   input  logic       reset_n,
   input  logic [7:0] byte_in,
   input  logic       byte_stb,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       full,
   output logic [4:0] count,
   output logic [1:0] state,
   output logic       frame_done,
   output logic       len_err,
   output logic       overflow
);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2
   } state_t;

   localparam logic [4:0] DEPTH_C = 5'(DEPTH);
   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   state_t     state_q;
   logic [4:0] remaining;
   logic [3:0] wr_ptr;
   logic [3:0] rd_ptr;
   logic [7:0] mem [0:15];

   logic pop;
   logic pay_stb;
   logic wr_fire;
   logic drop;

   assign empty   = (count == 5'd0);
   assign full    = (count == DEPTH_C);
   assign state   = state_q;
   assign rd_data = mem[rd_ptr];

   // A pop on a full FIFO frees the slot the same-cycle write lands in.
   assign pop     = rd_en && !empty;
   assign pay_stb = byte_stb && (state_q == PAYLOAD);
   assign wr_fire = pay_stb && (!full || pop);
   assign drop    = pay_stb && full && !pop;

   always_ff @(posedge ser_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= HUNT;
         remaining  <= 5'd0;
         wr_ptr     <= 4'd0;
         rd_ptr     <= 4'd0;
         count      <= 5'd0;
         frame_done <= 1'b0;
         len_err    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         len_err    <= 1'b0;
         if (drop)
            overflow <= 1'b1;
         if (wr_fire)
            wr_ptr <= wr_ptr + 4'd1;
         if (pop)
            rd_ptr <= rd_ptr + 4'd1;
         count <= count + {4'd0, wr_fire} - {4'd0, pop};

         case (state_q)
            HUNT: begin
               if (byte_stb && byte_in == HDR)
                  state_q <= LEN;
            end
            LEN: begin
               if (byte_stb) begin
                  if (byte_in == 8'd0) begin
                     frame_done <= 1'b1;
                     state_q    <= HUNT;
                  end else if (byte_in > DEPTH_B) begin
                     len_err <= 1'b1;
                     state_q <= HUNT;
                  end else begin
                     remaining <= byte_in[4:0];
                     state_q   <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (byte_stb) begin
                  remaining <= remaining - 5'd1;
                  if (remaining == 5'd1) begin
                     frame_done <= 1'b1;
                     state_q    <= HUNT;
                  end
               end
            end
            default: state_q <= HUNT;
         endcase
      end
   end

   // Storage is deliberately left out of reset; pointers alone define contents.
   always_ff @(posedge ser_clk) begin
      if (wr_fire)
         mem[wr_ptr] <= byte_in;
   end

endmodule

// File: tb/tb_frame_queue_ctrl.sv
// tb/tb_frame_queue_ctrl.sv - directed self-checking bench for frame_queue_ctrl
module tb_frame_queue_ctrl;

   logic       ser_clk = 1'b0;
   logic       reset_n;
   logic [7:0] byte_in;
   logic       byte_stb;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic [1:0] state;
   logic       frame_done;
   logic       len_err;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   frame_queue_ctrl #(.HDR(8'hAB), .DEPTH(16)) dut (
      .ser_clk    (ser_clk),
      .reset_n    (reset_n),
      .byte_in    (byte_in),
      .byte_stb   (byte_stb),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .state      (state),
      .frame_done (frame_done),
      .len_err    (len_err),
      .overflow   (overflow)
   );

   always #5 ser_clk = ~ser_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock with inputs applied at the falling edge; returns at the next falling edge.
   task automatic cycle(input logic stb, input logic [7:0] b, input logic rd);
      @(negedge ser_clk);
      byte_stb = stb;
      byte_in  = b;
      rd_en    = rd;
      @(negedge ser_clk);
      byte_stb = 1'b0;
      rd_en    = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0);
   endtask

   task automatic pop_one();
      cycle(1'b0, 8'h00, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge ser_clk);
      reset_n = 1'b0;
      @(negedge ser_clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n  = 1'b0;
      byte_in  = 8'h00;
      byte_stb = 1'b0;
      rd_en    = 1'b0;
      #1;
      check("rst_state", state, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_done", frame_done, 0);
      check("rst_lenerr", len_err, 0);
      check("rst_ovf", overflow, 0);
      @(negedge ser_clk);
      reset_n = 1'b1;

      // Basic three-byte frame
      send(8'hAB); check("f1_state_len", state, 1);
      send(8'h03); check("f1_state_pay", state, 2);
      send(8'h11); check("f1_state_p1", state, 2);
      send(8'h22); check("f1_state_p2", state, 2); check("f1_nodone", frame_done, 0);
      send(8'h33);
      check("f1_state_hunt", state, 0);
      check("f1_done", frame_done, 1);
      check("f1_count", count, 3);
      cycle(1'b0, 8'h00, 1'b0);
      check("f1_done_clr", frame_done, 0);
      check("f1_rd0", rd_data, 8'h11); pop_one();
      check("f1_rd1", rd_data, 8'h22); pop_one();
      check("f1_rd2", rd_data, 8'h33); pop_one();
      check("f1_empty", empty, 1);
      pop_one();
      check("f1_pop_empty_cnt", count, 0);

      // Zero length and illegal length
      send(8'hAB); send(8'h00);
      check("z_done", frame_done, 1); check("z_state", state, 0); check("z_count", count, 0);
      send(8'hAB); send(8'h11);
      check("l17_err", len_err, 1); check("l17_state", state, 0); check("l17_count", count, 0);
      cycle(1'b0, 8'h00, 1'b0);
      check("l17_err_clr", len_err, 0);

      // Header handling in HUNT/LEN/PAYLOAD
      send(8'h55); check("h_discard", state, 0);
      send(8'hAB); check("h_len", state, 1);
      send(8'hAB); check("h_lenhdr_err", len_err, 1); check("h_lenhdr_state", state, 0);
      send(8'hAB); send(8'h02); send(8'hAB); send(8'hAB);
      check("h_done", frame_done, 1); check("h_count", count, 2);
      check("h_rd0", rd_data, 8'hAB); pop_one();
      check("h_rd1", rd_data, 8'hAB); pop_one();
      check("h_empty", empty, 1);

      // Fill to 16, then a frame that must be dropped
      send(8'hAB); send(8'h10);
      for (int i = 0; i < 16; i++) send(8'h40 + 8'(i));
      check("o_done16", frame_done, 1);
      check("o_count16", count, 16); check("o_full", full, 1); check("o_ovf0", overflow, 0);
      send(8'hAB); send(8'h02); send(8'h99);
      check("o_ovf1", overflow, 1);
      send(8'h98);
      check("o_done2", frame_done, 1); check("o_count_hold", count, 16);
      check("o_head", rd_data, 8'h40);

      // Full with simultaneous pop/write, then drain across pointer wrap
      do_reset();
      check("w_rst_ovf", overflow, 0); check("w_rst_count", count, 0);
      send(8'hAB); send(8'h10);
      for (int i = 0; i < 16; i++) send(8'h60 + 8'(i));
      check("w_full", full, 1);
      send(8'hAB); send(8'h01);
      check("w_head", rd_data, 8'h60);
      cycle(1'b1, 8'h5A, 1'b1);
      check("w_cnt_same", count, 16); check("w_no_ovf", overflow, 0); check("w_done", frame_done, 1);
      for (int i = 0; i < 20; i++) begin
         if (i < 15) check("w_rd", rd_data, 8'h61 + 8'(i));
         else if (i == 15) check("w_rd_wrap", rd_data, 8'h5A);
         pop_one();
         check("w_cnt", count, (i < 16) ? 15 - i : 0);
      end
      check("w_empty", empty, 1);

      // Write into empty FIFO with a same-cycle pop request
      send(8'hAB); send(8'h01);
      cycle(1'b1, 8'h3C, 1'b1);
      check("e_cnt", count, 1); check("e_rd", rd_data, 8'h3C);
      pop_one();

      // Asynchronous reset mid-payload
      send(8'hAB); send(8'h08);
      for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i));
      check("a_count5", count, 5); check("a_state_pay", state, 2);
      #2 reset_n = 1'b0;
      #1;
      check("a_state", state, 0); check("a_count", count, 0); check("a_empty", empty, 1);
      check("a_full", full, 0); check("a_ovf", overflow, 0);
      #1 reset_n = 1'b1;
      send(8'hAB); send(8'h01); send(8'h7E);
      check("a_cnt1", count, 1); check("a_rd", rd_data, 8'h7E); check("a_done", frame_done, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
